ascii_msg_seq: RTL and testbench
================================

Name: ascii_msg_seq

Overview:
Parametrised character-message sequencer, the next generation of the fixed ring-counter-plus-coder name display. It stores up to DEPTH characters of WIDTH bits in a writable buffer and plays them out one per step strobe. Supported modes are one-shot or loop, and forward or reverse. It presents the current character, its index and a one-hot position vector. It sits between a host loader and the display/monitor logic.

Parameters:
WIDTH, 7, character width in bits (7 = ASCII)
DEPTH, 19, buffer entries (max message length)
AW, 5, index width; must satisfy 2^AW >= DEPTH

Ports:
CLK  input  1  clock, all state changes on posedge
RST_N  input  1  asynchronous active-low reset
wr_en  input  1  buffer write strobe
wr_addr  input  AW  write index
wr_data  input  WIDTH  character to write
len_m1  input  AW  message length minus 1, sampled on start
loop_mode  input  1  1 = wrap and replay, 0 = one-shot; sampled on start
reverse  input  1  1 = play last-to-first; sampled on start
start  input  1  begin playback (IDLE only)
stop  input  1  abort playback
step_en  input  1  advance one character
char_out  output  WIDTH  current character, registered
char_valid  output  1  char_out/pos meaningful
pos  output  AW  current index
pos_onehot  output  DEPTH  bit[pos] set while char_valid, else all zero
busy  output  1  state == RUN
done  output  1  one-cycle pulse on completing a pass

Behaviour:
- Reset (async, RST_N=0): state IDLE; buffer entries all 0; char_out=0, char_valid=0, pos=0, pos_onehot=0, busy=0, done=0; latched len/mode/dir = 0. Reset mid-playback aborts immediately with no done pulse.
- Two states: IDLE and RUN.
- Writes:
  - Any cycle, any state: wr_en=1 with wr_addr<DEPTH writes buf[wr_addr] at posedge.
  - wr_addr>=DEPTH: write ignored.
- IDLE -> RUN on start=1 and stop=0:
  - Latch last = min(len_m1, DEPTH-1), loop_mode and reverse.
  - pos = 0 (forward) or last (reverse).
  - Same edge: char_out = buf[new pos], char_valid=1, busy=1.
  - step_en is ignored on the start edge.
- Priority in RUN: stop > step_en. start is ignored while in RUN.
- RUN, stop=1: IDLE next edge; char_valid=0, pos_onehot=0, busy=0; pos and char_out hold; no done.
- RUN, step_en=1, pos not at end: pos = pos+1 (fwd) or pos-1 (rev); char_out = buf[new pos].
- RUN, step_en=1, pos at end (last if fwd, 0 if rev): done=1 for exactly one cycle. Then:
  - loop_mode=1: pos wraps to start index, char_out updates, stay RUN.
  - loop_mode=0: IDLE; char_valid=0, busy=0, pos/char_out hold.
- last=0: every step is an end step; in loop mode done pulses on every step.
- Write-through: if wr_en writes the address that char_out loads on that same edge, char_out takes wr_data.
- Writes to other addresses during RUN take effect when that index is next reached.
- In IDLE, start=1 together with stop=1: remain IDLE.
- Latency: one edge from step_en sampled high to the new char_out/pos.

Test Plan:
- Load "EHSAN" (45,48,53,41,4E hex) at 0..4; len_m1=4, fwd, one-shot, step_en=1 continuously -> char_out 45,48,53,41,4E on successive cycles; done=1 one cycle after 4E; then char_valid=0 and busy=0; pos_onehot goes 00001 through 10000, then 0.
- Same load, reverse=1, loop_mode=1 -> 4E,41,53,48,45,4E,...; done pulses once per 5 steps, coincident with the wrap back to 4E.
- len_m1=25 with DEPTH=19, loop, fwd -> pos runs 0..18 then wraps to 0; done pulses once per 19 steps; writing wr_addr=20 leaves all entries unchanged.
- Run with step_en toggling 1010...; assert stop at pos=2 together with step_en=1 -> next edge IDLE, pos stays 2, char_valid=0, no done.
- At pos=1 with step_en=1, write wr_addr=2, wr_data=5A -> char_out=5A on the next edge (write-through); later pass shows 5A at index 2.
- Deassert RST_N asynchronously mid-RUN, between clock edges -> all outputs 0 immediately; buffer reads 0 on the next run; start with start=stop=1 stays IDLE.

Source files
------------

// File: rtl/ascii_msg_seq_if.sv
// ascii_msg_seq_if: groups the host-loader and display-side signals of the
// character-message sequencer.
//   master : host/loader side (drives buffer writes and playback control,
//            observes the playback outputs)
//   slave  : the sequencer itself
// Signals:
//   wr_en/wr_addr/wr_data          buffer write port
//   len_m1/loop_mode/reverse       playback setup, sampled on start
//   start/stop/step_en             playback control
//   char_out/char_valid/pos        current character and its index
//   pos_onehot                     one-hot copy of pos while char_valid
//   busy/done                      running flag, end-of-pass pulse
interface ascii_msg_seq_if #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 19,
  parameter int AW    = 5
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    len_m1;
  logic             loop_mode;
  logic             reverse;
  logic             start;
  logic             stop;
  logic             step_en;
  logic [WIDTH-1:0] char_out;
  logic             char_valid;
  logic [AW-1:0]    pos;
  logic [DEPTH-1:0] pos_onehot;
  logic             busy;
  logic             done;

  modport master (
    output wr_en, wr_addr, wr_data, len_m1, loop_mode, reverse,
           start, stop, step_en,
    input  char_out, char_valid, pos, pos_onehot, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len_m1, loop_mode, reverse,
           start, stop, step_en,
    output char_out, char_valid, pos, pos_onehot, busy, done
  );
endinterface

// File: rtl/ascii_msg_seq.sv
// ascii_msg_seq: writable character buffer played out one entry per step
// strobe, one-shot or looping, forward or reverse.
// Ports:
//   CLK    clock, all state changes on posedge
//   RST_N  asynchronous active-low reset
//   bus    ascii_msg_seq_if.slave (write port, playback control, outputs)
// char_out is registered; pos_onehot and busy/char_valid are decoded from
// registered state.
module ascii_msg_seq #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 19,
  parameter int AW    = 5
) (
  input  logic            CLK,
  input  logic            RST_N,
  ascii_msg_seq_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [AW-1:0] LAST_MAX  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] char_q, char_d;
  logic [AW-1:0]    pos_q, pos_d;
  logic [AW-1:0]    last_q, last_d;
  logic             loop_q, loop_d;
  logic             rev_q, rev_d;
  logic             done_q, done_d;
  logic             load;
  logic             at_end;
  logic             wr_ok;

  // Out-of-range write addresses are dropped rather than aliased.
  assign wr_ok  = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_EXT);
  assign at_end = rev_q ? (pos_q == '0) : (pos_q == last_q);

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    last_d  = last_q;
    loop_d  = loop_q;
    rev_d   = rev_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          last_d  = (bus.len_m1 > LAST_MAX) ? LAST_MAX : bus.len_m1;
          loop_d  = bus.loop_mode;
          rev_d   = bus.reverse;
          pos_d   = bus.reverse ? last_d : '0;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.step_en) begin
          if (at_end) begin
            done_d = 1'b1;
            if (loop_q) begin
              pos_d = rev_q ? last_q : '0;
              load  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            pos_d = rev_q ? (pos_q - AW'(1)) : (pos_q + AW'(1));
            load  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A write landing on the entry being loaded this edge is forwarded so
    // char_out never shows the stale value.
    char_d = char_q;
    if (load) begin
      char_d = (wr_ok && (bus.wr_addr == pos_d)) ? bus.wr_data : mem[pos_d];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      char_q  <= '0;
      pos_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      rev_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      pos_q   <= pos_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      rev_q   <= rev_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the buffer is reset because a fresh run after reset must read
  // zeros; this forces flops instead of a RAM macro, acceptable at this size.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.char_out   = char_q;
  assign bus.pos        = pos_q;
  assign bus.busy       = (state_q == RUN);
  assign bus.char_valid = (state_q == RUN);
  assign bus.done       = done_q;
  assign bus.pos_onehot = (state_q == RUN) ? (DEPTH'(1) << pos_q) : '0;

endmodule

// File: tb/tb_ascii_msg_seq.sv
// tb_ascii_msg_seq: directed test of ascii_msg_seq. A behavioural reference
// model predicts every cycle's outputs when stimulus is applied; predictions
// are queued and compared after the clock edge.
module tb_ascii_msg_seq;

  localparam int WIDTH = 7;
  localparam int DEPTH = 19;
  localparam int AW    = 5;

  logic clk;
  logic rst_n;

  ascii_msg_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) bus ();

  ascii_msg_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] ch;
    logic [AW-1:0]    pos;
    logic             valid;
    logic             done;
    logic [DEPTH-1:0] oh;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_cyc    = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_run;
  int               m_pos;
  int               m_last;
  bit               m_loop;
  bit               m_rev;
  logic [WIDTH-1:0] m_char;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h",
                tag, n_cyc, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_run  = 0;
    m_pos  = 0;
    m_last = 0;
    m_loop = 0;
    m_rev  = 0;
    m_char = '0;
  endtask

  // One clock: drive inputs, predict, clock, compare.
  task automatic cyc(input logic st, input logic sp, input logic se,
                     input logic we = 1'b0, input int wa = 0,
                     input logic [WIDTH-1:0] wd = '0);
    exp_t e;
    bit   ld;
    bus.start   = st;
    bus.stop    = sp;
    bus.step_en = se;
    bus.wr_en   = we;
    bus.wr_addr = AW'(wa);
    bus.wr_data = wd;

    ld     = 0;
    e.done = 1'b0;
    if (!m_run) begin
      if (st && !sp) begin
        m_last = (int'(bus.len_m1) > DEPTH - 1) ? DEPTH - 1 : int'(bus.len_m1);
        m_loop = bus.loop_mode;
        m_rev  = bus.reverse;
        m_pos  = m_rev ? m_last : 0;
        m_run  = 1;
        ld     = 1;
      end
    end else if (sp) begin
      m_run = 0;
    end else if (se) begin
      if ((m_rev && m_pos == 0) || (!m_rev && m_pos == m_last)) begin
        e.done = 1'b1;
        if (m_loop) begin
          m_pos = m_rev ? m_last : 0;
          ld    = 1;
        end else begin
          m_run = 0;
        end
      end else begin
        m_pos = m_rev ? m_pos - 1 : m_pos + 1;
        ld    = 1;
      end
    end
    if (we && wa < DEPTH) m_mem[wa] = wd;
    if (ld) m_char = m_mem[m_pos];

    e.ch    = m_char;
    e.pos   = AW'(m_pos);
    e.valid = m_run;
    e.oh    = '0;
    if (m_run) e.oh[m_pos] = 1'b1;
    sb.push_back(e);

    @(posedge clk);
    #1;
    n_cyc++;
    e = sb.pop_front();
    check("char_out",   32'(bus.char_out),   32'(e.ch));
    check("pos",        32'(bus.pos),        32'(e.pos));
    check("char_valid", 32'(bus.char_valid), 32'(e.valid));
    check("busy",       32'(bus.busy),       32'(e.valid));
    check("done",       32'(bus.done),       32'(e.done));
    check("pos_onehot", 32'(bus.pos_onehot), 32'(e.oh));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_char"},  32'(bus.char_out),   32'h0);
    check({tag, "_valid"}, 32'(bus.char_valid), 32'h0);
    check({tag, "_pos"},   32'(bus.pos),        32'h0);
    check({tag, "_oh"},    32'(bus.pos_onehot), 32'h0);
    check({tag, "_busy"},  32'(bus.busy),       32'h0);
    check({tag, "_done"},  32'(bus.done),       32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ehsan [5];
    ehsan[0] = 7'h45; ehsan[1] = 7'h48; ehsan[2] = 7'h53;
    ehsan[3] = 7'h41; ehsan[4] = 7'h4E;

    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len_m1 = '0; bus.loop_mode = 0; bus.reverse = 0;
    bus.start = 0; bus.stop = 0; bus.step_en = 0;
    model_reset();

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Load EHSAN at 0..4 and distinct letters elsewhere.
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, i, ehsan[i]);
    for (int i = 5; i < DEPTH; i++) cyc(0, 0, 0, 1, i, 7'(7'h61 + i));

    // Forward one-shot, step held high.
    bus.len_m1 = 5'd4; bus.loop_mode = 0; bus.reverse = 0;
    cyc(1, 0, 1);
    repeat (6) cyc(0, 0, 1);

    // Reverse loop; a start during RUN must be ignored.
    bus.reverse = 1; bus.loop_mode = 1;
    cyc(1, 0, 0);
    repeat (7) cyc(0, 0, 1);
    cyc(1, 0, 0);
    repeat (6) cyc(0, 0, 1);
    cyc(0, 1, 1);

    // Length clamp to DEPTH; out-of-range write mid-run.
    bus.len_m1 = 5'd25; bus.reverse = 0; bus.loop_mode = 1;
    cyc(1, 0, 1);
    repeat (20) cyc(0, 0, 1);
    cyc(0, 0, 1, 1, 20, 7'h7F);
    repeat (21) cyc(0, 0, 1);
    cyc(0, 1, 0);

    // Single-entry loop: every step is an end step.
    bus.len_m1 = 5'd0;
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 1);
    cyc(0, 1, 0);

    // Toggling step, stop at pos 2 together with step_en.
    bus.len_m1 = 5'd4; bus.loop_mode = 0;
    cyc(1, 0, 0);
    cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 1);
    cyc(0, 1, 1);
    cyc(0, 0, 1);

    // Write-through at pos 1 -> 2, then a later pass sees 5A.
    bus.loop_mode = 1;
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1, 1, 2, 7'h5A);
    repeat (7) cyc(0, 0, 1);

    // Asynchronous reset between edges while running.
    bus.start = 0; bus.stop = 0; bus.step_en = 0; bus.wr_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    #2;
    rst_n = 1'b1;

    // Buffer reads zero after reset; start with stop stays IDLE.
    bus.len_m1 = 5'd4; bus.loop_mode = 0; bus.reverse = 0;
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    repeat (6) cyc(0, 0, 1);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
